// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   localparam int unsigned WORD_W       = 32;
   localparam int unsigned DMEM_ADDR_W  = 10;
   localparam int unsigned DMEM_LATENCY = 2;

   // ResultSrc encoding that control decodes into MemRead
   localparam logic [1:0]  RESULT_SRC_MEM = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: asynchronous read, synchronous write.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WORD_W-1:0] r_mem [DEPTH];

   // Write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I core load/store port with wait states.
// Optional misaligned-access detection is enabled by DMEM_MISALIGN_CHK_EN.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W  = DMEM_ADDR_W,
   parameter int unsigned LATENCY = DMEM_LATENCY
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [WORD_W-1:0] Addr,
   input  logic [WORD_W-1:0] WriteData,
   output logic [WORD_W-1:0] ReadData,
   output logic              stall
`ifdef DMEM_MISALIGN_CHK_EN
   ,
   output logic              MisalignErr
`endif
);

   localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
   // The request cycle is the first wait state, so WAIT covers the remaining LATENCY-1
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

   dmem_state_e       r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [WORD_W-1:0] r_read_data;
   logic              r_misalign;

   logic              w_req, w_is_read, w_is_write;
   logic              w_in_range, w_misalign;
   logic [ADDR_W-1:0] w_idx;
   logic [WORD_W-1:0] w_arr_rdata, w_rdata;
   logic              w_stall, w_capture, w_we, w_flag;

   assign w_req      = MemRead | MemWrite;
   assign w_is_write = MemWrite;
   assign w_is_read  = MemRead & ~MemWrite;
   assign w_idx      = Addr[ADDR_W+1:2];
   assign w_in_range = ((Addr >> (ADDR_W + 2)) == '0);
   assign w_rdata    = w_in_range ? w_arr_rdata : '0;

`ifdef DMEM_MISALIGN_CHK_EN
   assign w_misalign = (Addr[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_idx),
      .i_wdata (WriteData),
      .o_rdata (w_arr_rdata)
   );

   // Next-state, wait counter, capture and commit decisions
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_capture   = 1'b0;
      w_we        = 1'b0;
      w_flag      = 1'b0;
      if (LATENCY == 0) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_capture   = w_is_read;
         w_we        = w_is_write & w_in_range & ~w_misalign;
         w_flag      = w_req & w_misalign;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  w_stall = 1'b1;
                  if (LATENCY == 1) begin
                     w_state_nxt = DONE;
                     w_capture   = w_is_read;
                     w_flag      = w_misalign;
                  end else begin
                     w_state_nxt = WAIT;
                     w_cnt_nxt   = CNT_LOAD;
                  end
               end
            end
            WAIT: begin
               w_stall = 1'b1;
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end else begin
                  w_state_nxt = DONE;
                  w_capture   = w_is_read;
                  w_flag      = w_req & w_misalign;
               end
            end
            DONE: begin
               w_state_nxt = IDLE;
               w_we        = w_is_write & w_in_range & ~w_misalign;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // State, counter, load data and error flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_read_data <= '0;
         r_misalign  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_misalign <= w_flag;
         if (w_capture) begin
            r_read_data <= w_rdata;
         end
      end
   end

   // Stall is combinational so the request cycle itself freezes the PC
   assign stall    = reset_n & w_stall;
   assign ReadData = ((LATENCY == 0) && w_is_read) ? w_rdata : r_read_data;

`ifdef DMEM_MISALIGN_CHK_EN
   assign MisalignErr = r_misalign;
`else
   logic w_unused_misalign;
   assign w_unused_misalign = r_misalign;
`endif

endmodule
